// File: rtl/vga_console.sv
// vga_console: 96x32 text console buffer with host character port, VGA scan-out read port and clear/scroll engine.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_char/in_color host character stream;
//   vga_addr -> ch/color registered scan-out read (1-cycle latency); cur_col/cur_row cursor position.
// Build option: define VGA_SCROLL_EN to scroll the screen on row overflow instead of wrapping to row 0.
module vga_console (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic [7:0]  in_color,
  input  logic [11:0] vga_addr,
  output logic [7:0]  ch,
  output logic [7:0]  color,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row
);
  localparam logic [15:0] SPACE = 16'h2007;
`ifdef VGA_SCROLL_EN
  typedef enum logic [1:0] {IDLE, PUT, SCROLL, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, PUT, CLEAR} state_t;
`endif
  state_t      state;
  logic [15:0] mem [3072];
  logic [7:0]  pc, pk;
  logic [11:0] cnt, cur_addr, wa;
  logic [15:0] wd;
  logic        we, is_wr, is_bs, nl, adv;
  logic [6:0]  n_col;
  logic [4:0]  n_row;
  assign in_ready = state == IDLE;
  assign cur_addr = 12'(cur_row) * 12'd96 + 12'(cur_col);
  assign is_wr = pc < 8 || pc == 9 || pc == 11 || (pc >= 32 && pc <= 126);
  assign is_bs = pc == 8 && cur_col != 7'd0;
  assign nl = (is_wr && cur_col == 7'd95) || pc == 10;
  assign adv = is_wr && cur_col != 7'd95;
  assign n_col = (nl || pc == 13) ? 7'd0 : adv ? cur_col + 7'd1 : is_bs ? cur_col - 7'd1 : cur_col;
  // Row 31 + 1 wraps to row 0, which is exactly the non-scrolling overflow behaviour.
  assign n_row = nl ? cur_row + 5'd1 : cur_row;
`ifdef VGA_SCROLL_EN
  logic        ovf;
  logic [15:0] rd;
  assign ovf = nl && cur_row == 5'd31;
  // Copy pipeline: source cell cnt+96 is read this cycle and written to cnt the next.
  always_ff @(posedge clk) rd <= mem[cnt < 12'd2976 ? cnt + 12'd96 : 12'd0];
`endif
  always_comb begin
    we = state == CLEAR || (state == PUT && (is_wr || is_bs));
    wa = state == CLEAR ? cnt : is_bs ? cur_addr - 12'd1 : cur_addr;
    wd = (state == PUT && is_wr) ? {pc, pk} : SPACE;
`ifdef VGA_SCROLL_EN
    if (state == SCROLL) begin
      we = cnt != 12'd0;
      wa = cnt - 12'd1;
      wd = cnt <= 12'd2976 ? rd : SPACE;
    end
`endif
  end
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {ch, color} <= 16'd0;
    else {ch, color} <= vga_addr < 12'd3072 ? mem[vga_addr] : 16'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      cnt <= 12'd0;
      cur_col <= 7'd0;
      cur_row <= 5'd0;
      pc <= 8'd0;
      pk <= 8'd0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          pc <= in_char;
          pk <= in_color;
          state <= PUT;
        end
        PUT: begin
          cnt <= 12'd0;
          if (pc == 12) state <= CLEAR;
`ifdef VGA_SCROLL_EN
          else if (ovf) state <= SCROLL;
`endif
          else begin
            cur_col <= n_col;
            cur_row <= n_row;
            state <= IDLE;
          end
        end
`ifdef VGA_SCROLL_EN
        SCROLL: if (cnt == 12'd3072) begin
          state <= IDLE;
          cur_col <= 7'd0;
          cur_row <= 5'd31;
        end else cnt <= cnt + 12'd1;
`endif
        CLEAR: if (cnt == 12'd3071) begin
          state <= IDLE;
          cur_col <= 7'd0;
          cur_row <= 5'd0;
        end else cnt <= cnt + 12'd1;
        default: state <= CLEAR;
      endcase
endmodule

// File: tb/tb_vga_console.sv
// tb_vga_console: self-checking bench for vga_console (table of host characters plus clear/scroll/reset sequences).
module tb_vga_console;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0;
  logic [7:0] in_char = 8'd0, in_color = 8'd0;
  logic [11:0] vga_addr = 12'd0;
  logic in_ready;
  logic [7:0] ch, color;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  always #5 clk = ~clk;
  vga_console dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
                   .in_color(in_color), .vga_addr(vga_addr), .ch(ch), .color(color), .cur_col(cur_col), .cur_row(cur_row));
  int n_chk = 0, n_fail = 0;
  logic [15:0] mem_m [3072];
  typedef struct {int a; logic [15:0] d;} rd_t;
  rd_t sb[$];
  typedef struct {logic [7:0] c; logic [7:0] k; int col; int row; int wa; logic [15:0] wd;} vec_t;
  vec_t tbl[15];
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rdy(output int n);
    n = 0;
    while (!in_ready && n < 10000) begin
      step();
      n++;
    end
    chk("ready_bound", int'(in_ready), 1);
  endtask
  task automatic xfer(input logic [7:0] c, input logic [7:0] k);
    int n;
    wait_rdy(n);
    in_valid = 1'b1;
    in_char = c;
    in_color = k;
    step();
    in_valid = 1'b0;
  endtask
  task automatic send(input logic [7:0] c, input logic [7:0] k, output int lat);
    xfer(c, k);
    wait_rdy(lat);
  endtask
  // Each cycle drives a new address and pushes its expected cell; the result is popped one edge later.
  task automatic scan(input int a0, input int n);
    rd_t r;
    for (int i = 0; i < n; i++) begin
      vga_addr = 12'(a0 + i);
      sb.push_back('{a0 + i, (a0 + i < 3072) ? mem_m[a0 + i] : 16'h0000});
      step();
      r = sb.pop_front();
      chk($sformatf("cell%0d", r.a), int'({ch, color}), int'(r.d));
    end
  endtask
  task automatic clr_model;
    for (int i = 0; i < 3072; i++) mem_m[i] = 16'h2007;
  endtask
  task automatic chk_cur(input int col, input int row);
    chk("cur_col", int'(cur_col), col);
    chk("cur_row", int'(cur_row), row);
  endtask
  task automatic chk_reset_outs;
    chk("rst_in_ready", int'(in_ready), 0);
    chk_cur(0, 0);
    chk("rst_chcolor", int'({ch, color}), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int lat, n;
    tbl[0]  = '{8'd65,  8'd2, 1, 0, 0,   16'h4102};
    tbl[1]  = '{8'd10,  8'd0, 0, 1, -1,  16'h0000};
    tbl[2]  = '{8'd66,  8'd5, 1, 1, 96,  16'h4205};
    tbl[3]  = '{8'd13,  8'd0, 0, 1, -1,  16'h0000};
    tbl[4]  = '{8'd8,   8'd0, 0, 1, -1,  16'h0000};
    tbl[5]  = '{8'd10,  8'd0, 0, 2, -1,  16'h0000};
    tbl[6]  = '{8'd120, 8'd3, 1, 2, 192, 16'h7803};
    tbl[7]  = '{8'd121, 8'd4, 2, 2, 193, 16'h7904};
    tbl[8]  = '{8'd122, 8'd6, 3, 2, 194, 16'h7A06};
    tbl[9]  = '{8'd8,   8'd0, 2, 2, 194, 16'h2007};
    tbl[10] = '{8'd200, 8'd1, 2, 2, -1,  16'h0000};
    tbl[11] = '{8'd127, 8'd1, 2, 2, -1,  16'h0000};
    tbl[12] = '{8'd0,   8'd7, 3, 2, 194, 16'h0007};
    tbl[13] = '{8'd9,   8'd1, 4, 2, 195, 16'h0901};
    tbl[14] = '{8'd11,  8'd2, 5, 2, 196, 16'h0B02};
    #2 rst_n = 1'b0;
    #1 chk_reset_outs();
    repeat (3) begin
      step();
      chk("rst_hold_ready", int'(in_ready), 0);
    end
    rst_n = 1'b1;
    wait_rdy(n);
    chk("clear_cycles", n, 3072);
    clr_model();
    chk_cur(0, 0);
    scan(0, 3072);
    scan(3072, 1);
    scan(4095, 1);
    for (int i = 0; i < 15; i++) begin
      send(tbl[i].c, tbl[i].k, lat);
      if (tbl[i].wa >= 0) mem_m[tbl[i].wa] = tbl[i].wd;
      chk("put_lat", lat, 1);
      chk_cur(tbl[i].col, tbl[i].row);
    end
    scan(0, 200);
    send(8'd12, 8'd0, lat);
    chk("ff_lat", lat, 3073);
    clr_model();
    chk_cur(0, 0);
    for (int i = 0; i < 96; i++) begin
      send(8'(33 + i % 90), 8'(i % 8), lat);
      mem_m[i] = {8'(33 + i % 90), 8'(i % 8)};
    end
    chk_cur(0, 1);
    send(8'd81, 8'd3, lat);
    mem_m[96] = 16'h5103;
    chk_cur(1, 1);
    scan(0, 100);
    repeat (30) send(8'd10, 8'd0, lat);
    chk_cur(0, 31);
    for (int i = 0; i < 95; i++) begin
      send(8'(48 + i % 10), 8'd6, lat);
      mem_m[2976 + i] = {8'(48 + i % 10), 8'd6};
    end
    chk_cur(95, 31);
    send(8'd90, 8'd2, lat);
    mem_m[3071] = 16'h5A02;
`ifdef VGA_SCROLL_EN
    chk("scroll_lat", lat, 1 + 3073);
    chk_cur(0, 31);
    for (int a = 0; a < 2976; a++) mem_m[a] = mem_m[a + 96];
    for (int a = 2976; a < 3072; a++) mem_m[a] = 16'h2007;
`else
    chk("wrap_lat", lat, 1);
    chk_cur(0, 0);
`endif
    scan(0, 192);
    scan(2880, 192);
`ifndef VGA_SCROLL_EN
    send(8'd87, 8'd1, lat);
    mem_m[0] = 16'h5701;
    chk_cur(1, 0);
    scan(0, 3);
`endif
    scan(3071, 1);
`ifdef VGA_SCROLL_EN
    xfer(8'd10, 8'd0);
`else
    xfer(8'd12, 8'd0);
`endif
    repeat (100) step();
    chk("busy_ready", int'(in_ready), 0);
    chk("pre_rst_cell", int'({ch, color}), int'(mem_m[3071]));
    #2 rst_n = 1'b0;
    #1 chk_reset_outs();
    repeat (3) begin
      step();
      chk("rst_hold_ready", int'(in_ready), 0);
      chk("rst_hold_ch", int'({ch, color}), 0);
    end
    rst_n = 1'b1;
    wait_rdy(n);
    chk("clear_cycles2", n, 3072);
    clr_model();
    chk_cur(0, 0);
    scan(0, 3072);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
